// File: rtl/switch_allocator_rr.sv
// Wormhole switch allocator: one round-robin arbiter per output port.
// Grants are combinational (SA stage); crossbar selects are registered (ST stage).
// An output stays locked to its owner input until that input's tail flit passes,
// and the round-robin pointer only moves on packet completion.

// Per-output arbiter: lock/owner/pointer state plus registered crossbar select.
module switch_allocator_rr_arb #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ready,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_sel
);
  logic [SEL_W-1:0] ptr, owner, win_idx, cand;
  logic [SEL_W:0]   sum;
  logic             locked, win_vld;

  // Pick the winner: locked owner only, else first requester from ptr with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    if (rst_n && en && ready) begin
      if (locked) begin
        win_vld = req[owner];
        win_idx = win_vld ? owner : '0;
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          // ptr + k < 2*NUM_PORTS, so one conditional subtract is an exact modulo
          sum = {1'b0, ptr} + (SEL_W+1)'(k);
          if (sum >= (SEL_W+1)'(NUM_PORTS)) sum = sum - (SEL_W+1)'(NUM_PORTS);
          cand = sum[SEL_W-1:0];
          if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
          end
        end
      end
    end
  end

  // One-hot grant back towards the inputs.
  always_comb begin
    grant = '0;
    if (win_vld) grant[win_idx] = 1'b1;
  end

  // Advance lock/pointer state and register the crossbar select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (en) begin
      out_valid <= win_vld;
      out_sel   <= win_idx;
      if (win_vld) begin
        if (tail[win_idx]) begin
          locked <= 1'b0;
          ptr    <= (win_idx == SEL_W'(NUM_PORTS-1)) ? '0 : win_idx + SEL_W'(1);
        end else begin
          locked <= 1'b1;
          owner  <= win_idx;
        end
      end
    end
  end
endmodule

// Top: decode per-output request vectors, run one arbiter per output, merge grants.
module switch_allocator_rr #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS*SEL_W-1:0] in_dst,
  input  logic [NUM_PORTS-1:0]       in_tail,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS-1:0]       in_grant,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [NUM_PORTS*SEL_W-1:0] out_sel
);
  // req_m[o][i]: input i wants output o; gnt_m[o][i]: output o grants input i
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_m, gnt_m;

  // Destination decode; out-of-range destinations match no output.
  always_comb begin
    req_m = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        req_m[o][i] = in_valid[i] && (in_dst[i*SEL_W +: SEL_W] == SEL_W'(o));
  end

  // Each input names a single output, so at most one term is set per input.
  always_comb begin
    in_grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) in_grant = in_grant | gnt_m[o];
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    switch_allocator_rr_arb #(.NUM_PORTS(NUM_PORTS), .SEL_W(SEL_W)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .ready     (out_ready[o]),
      .req       (req_m[o]),
      .tail      (in_tail),
      .grant     (gnt_m[o]),
      .out_valid (out_valid[o]),
      .out_sel   (out_sel[o*SEL_W +: SEL_W])
    );
  end
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Bench for switch_allocator_rr (N=5): directed scenarios followed by random
// traffic, all compared against a per-output lock/owner/pointer model.
module tb_switch_allocator_rr;
  localparam int N  = 5;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic [N-1:0]  in_valid, in_tail, out_ready, in_grant, out_valid;
  logic [N*SW-1:0] in_dst, out_sel;

  int n_chk = 0, n_fail = 0;
  int m_ptr[N], m_own[N], e_ov[N], e_os[N], win[N];
  bit m_lock[N];
  logic [N-1:0]    g_seen, ov_seen;
  logic [N*SW-1:0] os_seen;
  int rem[N], pdst[N];

  always #5 clk = ~clk;

  switch_allocator_rr #(.NUM_PORTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_dst(in_dst),
    .in_tail(in_tail), .out_ready(out_ready), .in_grant(in_grant),
    .out_valid(out_valid), .out_sel(out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i, input bit v, input int d, input bit t);
    in_valid[i] = v;
    in_dst[i*SW +: SW] = SW'(d);
    in_tail[i] = t;
  endtask

  function automatic int dst_of(input int i);
    logic [N*SW-1:0] d;
    d = in_dst;
    return int'(d[i*SW +: SW]);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_ptr[o] = 0; m_own[o] = 0; m_lock[o] = 0; e_ov[o] = 0; e_os[o] = 0;
    end
  endtask

  // Winner per output from the allocation rules, using modulo arithmetic.
  task automatic model_wins();
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (rst_n && en && out_ready[o]) begin
        if (m_lock[o]) begin
          if (in_valid[m_own[o]] && dst_of(m_own[o]) == o) win[o] = m_own[o];
        end else begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr[o] + k) % N;
            if (win[o] < 0 && in_valid[i] && dst_of(i) == o) win[o] = i;
          end
        end
      end
    end
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic tick();
    logic [N-1:0] g;
    @(negedge clk);
    model_wins();
    g = '0;
    for (int o = 0; o < N; o++) if (win[o] >= 0) g[win[o]] = 1'b1;
    g_seen = in_grant; ov_seen = out_valid; os_seen = out_sel;
    chk("in_grant", in_grant, g);
    for (int o = 0; o < N; o++) begin
      chk($sformatf("out_valid[%0d]", o), out_valid[o], e_ov[o]);
      chk($sformatf("out_sel[%0d]", o), out_sel[o*SW +: SW], e_os[o]);
    end
    @(posedge clk);
    if (rst_n && en) begin
      for (int o = 0; o < N; o++) begin
        e_ov[o] = (win[o] >= 0);
        e_os[o] = (win[o] >= 0) ? win[o] : 0;
        if (win[o] >= 0) begin
          if (in_tail[win[o]]) begin
            m_lock[o] = 0; m_ptr[o] = (win[o] + 1) % N;
          end else begin
            m_lock[o] = 1; m_own[o] = win[o];
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = '1; in_tail = '1; in_dst = '0;
    in_valid = '1;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_grant", in_grant, 0);
    in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-flit requests from 1,3,4 to output 2: order 1,3,4
    set_in(1, 1, 2, 1); set_in(3, 1, 2, 1); set_in(4, 1, 2, 1);
    tick(); chk("s1_g0", g_seen, 5'b00010); in_valid &= ~g_seen;
    tick(); chk("s1_g1", g_seen, 5'b01000); chk("s1_sel0", os_seen[2*SW +: SW], 1);
    in_valid &= ~g_seen;
    tick(); chk("s1_g2", g_seen, 5'b10000); chk("s1_sel1", os_seen[2*SW +: SW], 3);
    in_valid &= ~g_seen;
    tick(); chk("s1_sel2", os_seen[2*SW +: SW], 4); chk("s1_ov2", ov_seen[2], 1);
    tick(); chk("s1_ov2_off", ov_seen[2], 0);

    // 4-flit packet from input 0 to output 3 vs. input 2 requesting continuously
    begin
      int cnt;
      cnt = 0;
      set_in(2, 1, 3, 1);
      for (int c = 0; c < 5; c++) begin
        set_in(0, cnt < 4, 3, cnt == 3);
        tick();
        chk($sformatf("s2_g%0d", c), g_seen, (c < 4) ? 5'b00001 : 5'b00100);
        if (g_seen[0]) cnt++;
        if (g_seen[2]) in_valid[2] = 1'b0;
      end
      in_valid = '0;
    end

    // Owner bubble on output 1: input 4 must not steal the lock
    set_in(0, 1, 1, 0); tick(); chk("s3_head", g_seen, 5'b00001);
    set_in(0, 0, 1, 0); set_in(4, 1, 1, 1);
    tick(); chk("s3_bub0", g_seen, 0);
    tick(); chk("s3_bub1", g_seen, 0); chk("s3_ov_b0", ov_seen[1], 0);
    set_in(0, 1, 1, 1);
    tick(); chk("s3_resume", g_seen, 5'b00001); chk("s3_ov_b1", ov_seen[1], 0);
    in_valid[0] = 1'b0;
    tick(); chk("s3_in4", g_seen, 5'b10000);
    in_valid = '0;

    // Stall on output 2, then same order as without the stall
    out_ready[2] = 1'b0;
    set_in(1, 1, 2, 1); set_in(3, 1, 2, 1); set_in(4, 1, 2, 1);
    for (int c = 0; c < 3; c++) begin
      tick(); chk($sformatf("s4_stall%0d", c), g_seen, 0);
      if (c > 0) chk($sformatf("s4_ov%0d", c), ov_seen[2], 0);
    end
    out_ready = '1;
    tick(); chk("s4_g0", g_seen, 5'b00010); chk("s4_ov_last", ov_seen[2], 0);
    in_valid &= ~g_seen;
    tick(); chk("s4_g1", g_seen, 5'b01000); in_valid &= ~g_seen;
    tick(); chk("s4_g2", g_seen, 5'b10000); in_valid &= ~g_seen;

    // Wrap: input 3's tail sets ptr[0]=4, then 4 beats 0
    set_in(3, 1, 0, 1); tick(); chk("s5_g3", g_seen, 5'b01000);
    in_valid = '0;
    set_in(0, 1, 0, 1); set_in(4, 1, 0, 1);
    tick(); chk("s5_wrap4", g_seen, 5'b10000); in_valid &= ~g_seen;
    tick(); chk("s5_then0", g_seen, 5'b00001); in_valid &= ~g_seen;

    // Non-conflicting permutation: all inputs granted together
    for (int i = 0; i < N; i++) set_in(i, 1, (i + 1) % N, 1);
    tick(); chk("s6_all", g_seen, 5'b11111);
    in_valid = '0;
    tick(); chk("s6_sel", os_seen, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4});
    chk("s6_ov", ov_seen, 5'b11111);

    // en=0 mid-packet keeps the lock and holds registered outputs
    set_in(1, 1, 4, 0); tick(); chk("s7_head", g_seen, 5'b00010);
    en = 1'b0; set_in(2, 1, 4, 1);
    tick(); chk("s7_hold0", g_seen, 0); chk("s7_ov0", ov_seen[4], 1);
    tick(); chk("s7_hold1", g_seen, 0); chk("s7_ov1", ov_seen[4], 1);
    en = 1'b1; set_in(1, 1, 4, 1);
    tick(); chk("s7_owner", g_seen, 5'b00010); in_valid[1] = 1'b0;
    tick(); chk("s7_next", g_seen, 5'b00100); in_valid = '0;

    // Reset mid-packet clears the lock immediately
    set_in(3, 1, 0, 0); tick(); chk("s8_head", g_seen, 5'b01000);
    set_in(2, 1, 0, 1);
    rst_n = 1'b0; #1;
    chk("s8_async_ov", out_valid, 0);
    chk("s8_async_g", in_grant, 0);
    model_reset();
    tick();
    rst_n = 1'b1; in_valid[3] = 1'b0;
    tick(); chk("s8_unlocked", g_seen, 5'b00100);
    in_valid = '0;

    // Random wormhole traffic with bubbles, stalls, en drops and bad destinations
    for (int i = 0; i < N; i++) begin rem[i] = 0; pdst[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      en = ($urandom_range(0, 9) != 0);
      out_ready = N'($urandom | $urandom);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          pdst[i] = $urandom_range(0, 6);
          rem[i] = (pdst[i] >= N) ? 1 : $urandom_range(1, 3);
        end
        set_in(i, rem[i] > 0 && $urandom_range(0, 3) != 0, pdst[i], rem[i] == 1);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (g_seen[i]) rem[i]--;
        else if (pdst[i] >= N) rem[i] = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
